// File: rtl/code_game_pkg.sv
// rtl/code_game_pkg.sv - shared state, prize and hint codes for the code-guessing game
package code_game_pkg;
  localparam logic [3:0] S0  = 4'b0000;
  localparam logic [3:0] S1  = 4'b0001;
  localparam logic [3:0] S2  = 4'b0010;
  localparam logic [3:0] S3  = 4'b0011;
  localparam logic [3:0] S4  = 4'b0100;
  localparam logic [3:0] SG1 = 4'b0101;
  localparam logic [3:0] SG2 = 4'b0110;
  localparam logic [3:0] SG0 = 4'b0111;
  localparam logic [3:0] SGX = 4'b1000;

  localparam logic [1:0] PR_NONE = 2'b00;
  localparam logic [1:0] PR_P1   = 2'b01;
  localparam logic [1:0] PR_P2   = 2'b10;

  localparam logic [1:0] H_NONE = 2'b00;
  localparam logic [1:0] H_LOW  = 2'b01;
  localparam logic [1:0] H_HIGH = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE   = S0,
    ST_SECRET = S1,
    ST_P1     = S2,
    ST_P2     = S3,
    ST_EXH    = S4,
    ST_WIN1   = SG1,
    ST_WIN2   = SG2,
    ST_NOWIN  = SG0,
    ST_ACK    = SGX
  } state_t;
endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - counts cycles spent in a hold state, pulses done on the last one
module hold_timer #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign done = en && (count == LAST);

  // Restarting on done lets back-to-back hold states each get a full period
  always_ff @(posedge clk) begin
    if (rst || clr || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/code_round_ctrl.sv
// rtl/code_round_ctrl.sv - single-round sequencer: secret entry, alternating guesses, prize decision
module code_round_ctrl
  import code_game_pkg::*;
#(
  parameter int CODE_W      = 4,
  parameter int MAX_TRIES   = 9,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load,
  input  logic              p1_sub,
  input  logic              p2_sub,
  input  logic [CODE_W-1:0] code_in,
  output logic [3:0]        state_f,
  output logic [1:0]        premio_f,
  output logic [4:0]        p1_f,
  output logic [4:0]        p2_f,
  output logic [1:0]        hint
);
  localparam logic [4:0] MAX5 = 5'(MAX_TRIES);

  state_t            state, state_n;
  logic [CODE_W-1:0] secret, secret_n;
  logic [1:0]        premio_n, hint_n;
  logic [4:0]        p1_n, p2_n;
  logic              in_hold, hold_done;

  assign state_f = state;
  assign in_hold = (state == ST_EXH) || (state == ST_WIN1) ||
                   (state == ST_WIN2) || (state == ST_NOWIN);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_hold),
    .en   (in_hold),
    .done (hold_done)
  );

  always_comb begin
    state_n  = state;
    secret_n = secret;
    premio_n = premio_f;
    p1_n     = p1_f;
    p2_n     = p2_f;
    hint_n   = hint;
    case (state)
      ST_IDLE: if (start) begin
        state_n  = ST_SECRET;
        p1_n     = '0;
        p2_n     = '0;
        premio_n = PR_NONE;
        hint_n   = H_NONE;
      end
      ST_SECRET: if (load) begin
        secret_n = code_in;
        state_n  = ST_P1;
      end
      ST_P1: if (p1_sub) begin
        p1_n = p1_f + 5'd1;
        if (code_in == secret) begin
          hint_n   = H_NONE;
          premio_n = PR_P1;
          state_n  = ST_WIN1;
        end else begin
          hint_n  = (code_in < secret) ? H_LOW : H_HIGH;
          state_n = ST_P2;
        end
      end
      ST_P2: if (p2_sub) begin
        p2_n = p2_f + 5'd1;
        if (code_in == secret) begin
          hint_n   = H_NONE;
          premio_n = PR_P2;
          state_n  = ST_WIN2;
        end else begin
          hint_n = (code_in < secret) ? H_LOW : H_HIGH;
          // P2 always plays last, so both players are out only after P2's final miss
          state_n = ((p1_f == MAX5) && (p2_f + 5'd1 == MAX5)) ? ST_EXH : ST_P1;
        end
      end
      ST_EXH: if (hold_done) state_n = ST_NOWIN;
      ST_WIN1, ST_WIN2, ST_NOWIN: if (hold_done) state_n = ST_ACK;
      ST_ACK: if (start) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      secret   <= '0;
      premio_f <= PR_NONE;
      p1_f     <= '0;
      p2_f     <= '0;
      hint     <= H_NONE;
    end else begin
      state    <= state_n;
      secret   <= secret_n;
      premio_f <= premio_n;
      p1_f     <= p1_n;
      p2_f     <= p2_n;
      hint     <= hint_n;
    end
  end
endmodule

// File: tb/tb_code_round_ctrl.sv
// tb/tb_code_round_ctrl.sv - self-checking bench for code_round_ctrl against a behavioural round model
module tb_code_round_ctrl;
  localparam int CW = 4;
  localparam int MT = 2;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0, start = 1'b0, load = 1'b0, p1_sub = 1'b0, p2_sub = 1'b0;
  logic [CW-1:0] code_in = '0;
  logic [3:0]    state_f;
  logic [1:0]    premio_f, hint;
  logic [4:0]    p1_f, p2_f;
  logic [17:0]   obs;

  int tests_run = 0;
  int tests_failed = 0;

  // Model of the round: phase uses the displayed state code, hold measured as cycles remaining
  int m_st, m_premio, m_p1, m_p2, m_hint, m_secret, m_left;

  code_round_ctrl #(.CODE_W(CW), .MAX_TRIES(MT), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .p1_sub(p1_sub), .p2_sub(p2_sub),
    .code_in(code_in), .state_f(state_f), .premio_f(premio_f), .p1_f(p1_f), .p2_f(p2_f),
    .hint
  );

  always #5 clk = ~clk;
  assign obs = {state_f, premio_f, p1_f, p2_f, hint};

  function automatic logic [17:0] mvec();
    return {4'(m_st), 2'(m_premio), 5'(m_p1), 5'(m_p2), 2'(m_hint)};
  endfunction

  function automatic int guess_hint(input int c);
    return (c < m_secret) ? 1 : 2;
  endfunction

  task automatic model_step(input bit r, st, ld, s1, s2, input int c);
    if (r) begin
      m_st = 0; m_premio = 0; m_p1 = 0; m_p2 = 0; m_hint = 0; m_secret = 0; m_left = 0;
    end else if (m_st == 0) begin
      if (st) begin m_st = 1; m_p1 = 0; m_p2 = 0; m_premio = 0; m_hint = 0; end
    end else if (m_st == 1) begin
      if (ld) begin m_secret = c; m_st = 2; end
    end else if (m_st == 2) begin
      if (s1) begin
        m_p1++;
        if (c == m_secret) begin m_hint = 0; m_premio = 1; m_st = 5; m_left = HC; end
        else begin m_hint = guess_hint(c); m_st = 3; end
      end
    end else if (m_st == 3) begin
      if (s2) begin
        m_p2++;
        if (c == m_secret) begin m_hint = 0; m_premio = 2; m_st = 6; m_left = HC; end
        else begin
          m_hint = guess_hint(c);
          if (m_p1 == MT && m_p2 == MT) begin m_st = 4; m_left = HC; end
          else m_st = 2;
        end
      end
    end else if (m_st >= 4 && m_st <= 7) begin
      m_left--;
      if (m_left == 0) begin
        if (m_st == 4) begin m_st = 7; m_left = HC; end
        else m_st = 8;
      end
    end else if (m_st == 8) begin
      if (st) m_st = 0;
    end
  endtask

  task automatic drive(input bit r, st, ld, s1, s2, input logic [CW-1:0] c);
    rst = r; start = st; load = ld; p1_sub = s1; p2_sub = s2; code_in = c;
    @(posedge clk);
    model_step(r, st, ld, s1, s2, int'(c));
    #1;
    rst = 1'b0; start = 1'b0; load = 1'b0; p1_sub = 1'b0; p2_sub = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 4'hF);
    drive(1, 1, 1, 1, 1, 4'hF);
    tests_run++;
    if (obs !== 18'h0 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", obs, 18'h0);
    end
  endtask

  task automatic test_p1_win();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b0101);
    tests_run++;
    if (state_f !== 4'b0010 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL p1win_load got=%h exp=%h", obs, mvec());
    end
    drive(0, 0, 0, 1, 0, 4'b0101);
    tests_run++;
    if (state_f !== 4'b0101 || premio_f !== 2'b01 || p1_f !== 5'd1 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL p1win_hit got=%h exp=%h", obs, mvec());
    end
    for (int i = 0; i < HC; i++) begin
      drive(0, 0, 0, 0, 0, 4'h0);
      tests_run++;
      if (state_f !== ((i == HC - 1) ? 4'b1000 : 4'b0101) || obs !== mvec()) begin
        tests_failed++;
        $display("FAIL p1win_hold%0d got=%h exp=%h", i, obs, mvec());
      end
    end
    drive(0, 1, 0, 0, 0, 4'h0);
    tests_run++;
    if (state_f !== 4'b0000 || premio_f !== 2'b01 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL p1win_ack got=%h exp=%h", obs, mvec());
    end
  endtask

  task automatic test_alternation();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b1010);
    drive(0, 0, 0, 1, 0, 4'b0011);
    tests_run++;
    if (p1_f !== 5'd1 || hint !== 2'b01 || state_f !== 4'b0011 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL alt_p1_low got=%h exp=%h", obs, mvec());
    end
    drive(0, 1, 0, 0, 0, 4'b1010);
    tests_run++;
    if (state_f !== 4'b0011 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL alt_start_in_s3 got=%h exp=%h", obs, mvec());
    end
    drive(0, 0, 0, 0, 1, 4'b1100);
    tests_run++;
    if (p2_f !== 5'd1 || hint !== 2'b10 || state_f !== 4'b0010 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL alt_p2_high got=%h exp=%h", obs, mvec());
    end
    drive(0, 0, 0, 0, 1, 4'b1010);
    tests_run++;
    if (p2_f !== 5'd1 || state_f !== 4'b0010 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL alt_p2_ignored got=%h exp=%h", obs, mvec());
    end
    drive(0, 0, 0, 1, 0, 4'b1010);
    tests_run++;
    if (state_f !== 4'b0101 || p1_f !== 5'd2 || hint !== 2'b00 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL alt_p1_win got=%h exp=%h", obs, mvec());
    end
  endtask

  task automatic test_p2_win();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b0111);
    drive(0, 0, 0, 1, 0, 4'b0000);
    drive(0, 0, 0, 0, 1, 4'b0111);
    tests_run++;
    if (state_f !== 4'b0110 || premio_f !== 2'b10 || p2_f !== 5'd1 || p1_f !== 5'd1 ||
        obs !== mvec()) begin
      tests_failed++;
      $display("FAIL p2win got=%h exp=%h", obs, mvec());
    end
  endtask

  task automatic test_exhaustion();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b0111);
    drive(0, 0, 0, 1, 0, 4'b0001);
    drive(0, 0, 0, 0, 1, 4'b1111);
    drive(0, 0, 0, 1, 0, 4'b0010);
    drive(0, 0, 0, 0, 1, 4'b1110);
    tests_run++;
    if (state_f !== 4'b0100 || p1_f !== 5'd2 || p2_f !== 5'd2 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL exh_enter got=%h exp=%h", obs, mvec());
    end
    for (int i = 1; i <= 2 * HC; i++) begin
      drive(0, 0, 0, 0, 0, 4'h0);
      tests_run++;
      if (state_f !== ((i < HC) ? 4'b0100 : (i < 2 * HC) ? 4'b0111 : 4'b1000) ||
          premio_f !== 2'b00 || obs !== mvec()) begin
        tests_failed++;
        $display("FAIL exh_hold%0d got=%h exp=%h", i, obs, mvec());
      end
    end
    drive(0, 0, 1, 1, 1, 4'b0111);
    tests_run++;
    if (state_f !== 4'b1000 || p1_f !== 5'd2 || p2_f !== 5'd2 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL exh_sgx_ignore got=%h exp=%h", obs, mvec());
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b1000);
    drive(0, 0, 0, 1, 1, 4'b0001);
    tests_run++;
    if (state_f !== 4'b0011 || p1_f !== 5'd1 || p2_f !== 5'd0 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL simul_sub got=%h exp=%h", obs, mvec());
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 1, 0, 0, 4'b0011);
    drive(0, 0, 0, 1, 0, 4'b0011);
    drive(0, 0, 0, 0, 0, 4'h0);
    drive(1, 1, 0, 0, 0, 4'h0);
    tests_run++;
    if (obs !== 18'h0 || obs !== mvec()) begin
      tests_failed++;
      $display("FAIL reset_mid_hold got=%h exp=%h", obs, 18'h0);
    end
  endtask

  task automatic test_random();
    bit r, st, ld, s1, s2;
    logic [CW-1:0] c;
    drive(1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 3) == 0);
      ld = ($urandom_range(0, 2) == 0);
      s1 = ($urandom_range(0, 2) == 0);
      s2 = ($urandom_range(0, 2) == 0);
      c  = CW'($urandom_range(0, 5));
      drive(r, st, ld, s1, s2, c);
      tests_run++;
      if (obs !== mvec()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, obs, mvec());
      end
    end
  endtask

  initial begin
    m_st = 0; m_premio = 0; m_p1 = 0; m_p2 = 0; m_hint = 0; m_secret = 0; m_left = 0;
    test_reset();
    test_p1_win();
    test_alternation();
    test_p2_win();
    test_exhaustion();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
